// File: rtl/risc_pkg.sv
// Shared definitions for the VERI_RISC program loader: opcodes, memory
// geometry defaults and the loader state encoding.
package risc_pkg;

  localparam int RISC_AW = 5;
  localparam int RISC_DW = 8;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CPU_RST = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } loader_state_e;

endpackage

// File: rtl/risc_prog_loader.sv
// Streams a program image into the VERI_RISC memory, holds the CPU in reset
// while loading, then runs it and counts clocks until halt or a cycle limit.
module risc_prog_loader
  import risc_pkg::*;
#(
  parameter int AW         = RISC_AW,
  parameter int DW         = RISC_DW,
  parameter int CW         = 16,
  parameter int MAX_CYCLES = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_write,
  output logic          cpu_rst,
  input  logic          halt,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);

  localparam logic [AW:0]   DEPTH     = {1'b1, {AW{1'b0}}};
  localparam logic [CW-1:0] CYCLE_MAX = CW'(MAX_CYCLES);

  loader_state_e state_q;
  logic [AW:0]   len_q;
  logic [AW-1:0] idx_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_data_q;
  logic          mem_write_q;
  logic          cpu_rst_q;
  logic          busy_q;
  logic          done_q;
  logic          timeout_q;
  logic [CW-1:0] count_q;

  logic [AW:0]   len_d;
  logic [CW-1:0] count_d;
  logic          last_byte;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    len_d = prog_len;
    if (prog_len > DEPTH) len_d = DEPTH;
    count_d = count_q;
    if (count_q != '1) count_d = count_q + 1'b1;
  end

  assign last_byte = ({1'b0, idx_q} == (len_q - 1'b1));

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_write_q <= 1'b0;
      cpu_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      mem_write_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            len_q     <= len_d;
            idx_q     <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
            cpu_rst_q <= 1'b1;
            state_q   <= (len_d != '0) ? ST_LOAD : ST_CPU_RST;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            mem_write_q <= 1'b1;
            mem_addr_q  <= idx_q;
            mem_data_q  <= in_data;
            idx_q       <= idx_q + 1'b1;
            if (last_byte) state_q <= ST_CPU_RST;
          end
        end
        ST_CPU_RST: begin
          // The CPU samples its reset on this edge; it runs from the next one.
          cpu_rst_q <= 1'b0;
          state_q   <= ST_RUN;
        end
        ST_RUN: begin
          if (halt || (count_q == CYCLE_MAX)) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            timeout_q <= !halt;
            busy_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
          end else begin
            count_q <= count_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == ST_LOAD);
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign mem_write   = mem_write_q;
  assign cpu_rst     = cpu_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_risc_prog_loader.sv
// Directed bench for risc_prog_loader with a small behavioural VERI_RISC
// (8 clocks per instruction, halt raised in the fourth clock of HLT).
module tb_risc_prog_loader;
  import risc_pkg::*;

  localparam int AW         = 5;
  localparam int DW         = 8;
  localparam int CW         = 16;
  localparam int MAX_CYCLES = 1023;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   prog_len;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_write;
  logic          cpu_rst;
  logic          halt;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_count;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;
  int snap;

  risc_prog_loader #(
    .AW(AW), .DW(DW), .CW(CW), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
    .cpu_rst(cpu_rst), .halt(halt), .busy(busy), .done(done),
    .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Behavioural memory plus CPU: fetch on clock 0, halt check on clock 3,
  // execute on clock 7 of each instruction.
  logic [7:0] mem [0:31];
  logic [2:0] phase;
  logic [4:0] pc;
  logic [7:0] ir;
  logic [7:0] acc;

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr] <= mem_data;
      wr_count      <= wr_count + 1;
    end
    if (cpu_rst) begin
      phase <= 3'd0;
      pc    <= 5'd0;
      ir    <= 8'd0;
      acc   <= 8'd0;
      halt  <= 1'b0;
    end else if (!halt) begin
      phase <= phase + 3'd1;
      case (phase)
        3'd0: begin
          ir <= mem[pc];
          pc <= pc + 5'd1;
        end
        3'd3: if (ir[7:5] == HLT) halt <= 1'b1;
        3'd7: begin
          case (ir[7:5])
            SKZ:     if (acc == 8'd0) pc <= pc + 5'd1;
            ADD:     acc <= acc + mem[ir[4:0]];
            AND:     acc <= acc & mem[ir[4:0]];
            XOR:     acc <= acc ^ mem[ir[4:0]];
            LDA:     acc <= mem[ir[4:0]];
            STO:     mem[ir[4:0]] <= acc;
            JMP:     pc <= ir[4:0];
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [AW:0] len);
    start    = 1'b1;
    prog_len = len;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic send_byte(input int idx, input logic [7:0] data, input int gap);
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = data;
    check("in_ready_load", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("wr_strobe", mem_write, 1);
    check("wr_addr", mem_addr, idx);
    check("wr_data", mem_data, data);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_within_budget", done, 1);
  endtask

  task automatic check_result(input string tag, input int exp_count, input logic exp_timeout);
    check({tag, "_done"}, done, 1);
    check({tag, "_timeout"}, timeout, exp_timeout);
    check({tag, "_count"}, cycle_count, exp_count);
    check({tag, "_cpu_rst"}, cpu_rst, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  logic [7:0] lda_prog [6];

  initial begin
    lda_prog = '{{LDA, 5'd5}, {SKZ, 5'd0}, {HLT, 5'd0}, {JMP, 5'd0}, 8'h00, 8'h01};
    rst      = 1'b1;
    start    = 1'b0;
    prog_len = '0;
    in_valid = 1'b0;
    in_data  = '0;
    tick(2);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_count", cycle_count, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    rst = 1'b0;
    tick(1);

    // Single HLT instruction.
    pulse_start(1);
    check("hlt_busy", busy, 1);
    check("hlt_cpu_rst_load", cpu_rst, 1);
    send_byte(0, {HLT, 5'd0}, 0);
    check("hlt_in_ready_after_last", in_ready, 0);
    check("hlt_cpu_rst_hold", cpu_rst, 1);
    wait_done(100);
    check_result("hlt", 4, 1'b0);

    // JMP 2, JMP 2, HLT with gaps between bytes.
    pulse_start(3);
    send_byte(0, {JMP, 5'd2}, 2);
    send_byte(1, {JMP, 5'd2}, 2);
    send_byte(2, {HLT, 5'd0}, 2);
    wait_done(200);
    check_result("jmp", 12, 1'b0);

    // LDA 5 (loads 1), SKZ (no skip), HLT.
    pulse_start(6);
    for (int i = 0; i < 6; i++) send_byte(i, lda_prog[i], 0);
    wait_done(200);
    check_result("lda", 20, 1'b0);

    // Re-run without loading; a start during RUN is ignored.
    snap = wr_count;
    pulse_start(0);
    check("rerun_in_ready", in_ready, 0);
    check("rerun_busy", busy, 1);
    check("rerun_cleared_done", done, 0);
    tick(10);
    check("rerun_cpu_running", cpu_rst, 0);
    pulse_start(1);
    check("rerun_start_ignored", in_ready, 0);
    wait_done(200);
    check_result("rerun", 20, 1'b0);
    check("rerun_no_writes", wr_count, snap);

    // Endless JMP 0 loop runs into the cycle limit.
    pulse_start(1);
    send_byte(0, {JMP, 5'd0}, 0);
    wait_done(1200);
    check_result("tmo", MAX_CYCLES, 1'b1);

    // Reset in the middle of a load.
    pulse_start(6);
    for (int i = 0; i < 3; i++) send_byte(i, lda_prog[i], 0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_cpu_rst", cpu_rst, 1);
    check("abort_in_ready", in_ready, 0);
    check("abort_mem_write", mem_write, 0);
    check("abort_count", cycle_count, 0);
    snap = wr_count;
    tick(5);
    check("abort_no_more_writes", wr_count, snap);
    in_valid = 1'b0;
    tick(1);

    // Oversized length saturates to 32 back-to-back bytes.
    pulse_start(40);
    snap     = wr_count;
    in_valid = 1'b1;
    in_data  = {HLT, 5'd0};
    tick(40);
    in_valid = 1'b0;
    tick(2);
    check("sat_write_count", wr_count - snap, 32);
    check_result("sat", 4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end, expected completion");
    $fatal(1);
  end

endmodule
